// File: rtl/fp_pkg.sv
// Shared field widths and FSM encoding for the linear <-> (S,E,F) converter pair.
package fp_pkg;

    localparam int EXP_W   = 3;
    localparam int MANT_W  = 4;
    localparam int OUT_W   = 12;
    localparam int MAX_MAG = 1920;  // 15 << 7, the largest expandable magnitude

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_NEG   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        NEG   = ST_NEG,
        HOLD  = ST_HOLD
    } state_t;

endpackage

// File: rtl/fp_expander.sv
// Expands a sign/exponent/significand triple into a 12-bit two's-complement value,
// one left shift per exponent step, behind valid/ready handshakes on both sides.
module fp_expander
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [EXP_W-1:0]  E,
    input  logic [MANT_W-1:0] F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  D_out,
    output logic              busy
);

    logic [1:0]       state;
    logic [OUT_W-1:0] acc;
    logic [EXP_W-1:0] cnt;
    logic             sgn;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // NOTE: all state here is sequential, so every assignment uses <= to avoid
    // read-after-write races between registers updated on the same edge.
    // NOTE: the datapath registers are reset too, so an aborted transaction
    // leaves nothing behind that could leak into the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            D_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= {{(OUT_W-MANT_W){1'b0}}, F};
                        cnt   <= E;
                        sgn   <= S;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        state <= ST_NEG;
                    end else begin
                        acc <= acc << 1;
                        cnt <= cnt - EXP_W'(1);
                    end
                end
                ST_NEG: begin
                    // F=0 negates to zero, so no negative zero can appear.
                    D_out     <= sgn ? (~acc + OUT_W'(1)) : acc;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_expander.sv
// Directed-vector bench for fp_expander: values, latency, handshake and reset abort.
module tb_fp_expander;
    import fp_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              S;
    logic [EXP_W-1:0]  E;
    logic [MANT_W-1:0] F;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  D_out;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int lat;

    fp_expander dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D_out     (D_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a triple, lets it be accepted, and counts edges (accept edge
    // included) until out_valid rises, bounded by a cycle budget.
    task automatic launch(input logic s, input logic [EXP_W-1:0] e,
                          input logic [MANT_W-1:0] f, output int n);
        @(negedge clk);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        S = s; E = e; F = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("not_ready_after_accept", 32'(in_ready), 32'd0);
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Consumes a HOLD result and checks the return to IDLE.
    task automatic drain(input logic [OUT_W-1:0] exp_d);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_dropped", 32'(out_valid), 32'd0);
        check("ready_restored", 32'(in_ready), 32'd1);
        check("dout_kept", 32'(D_out), 32'(exp_d));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        S = 1'b0; E = '0; F = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(D_out), 32'd0);
        // Inputs must be ignored while reset is held.
        in_valid = 1'b1; F = 4'd7;
        @(posedge clk); #1;
        check("rst_ignores_input", 32'(busy), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 1: pass-through, minimum latency
        launch(1'b0, 3'd0, 4'd13, lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_dout", 32'(D_out), 32'h00D);
        drain(12'h00D);

        // 2: largest positive magnitude
        launch(1'b0, 3'd7, 4'd15, lat);
        check("t2_latency", 32'(lat), 32'd10);
        check("t2_dout", 32'(D_out), 32'h780);
        drain(12'h780);

        // 3: negative results
        launch(1'b1, 3'd7, 4'd15, lat);
        check("t3a_latency", 32'(lat), 32'd10);
        check("t3a_dout", 32'(D_out), 32'h880);
        drain(12'h880);
        launch(1'b1, 3'd6, 4'd8, lat);
        check("t3b_latency", 32'(lat), 32'd9);
        check("t3b_dout", 32'(D_out), 32'hE00);
        drain(12'hE00);

        // 4: zero significand, negative sign
        launch(1'b1, 3'd3, 4'd0, lat);
        check("t4_latency", 32'(lat), 32'd6);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_dout", 32'(D_out), 32'h000);
        drain(12'h000);

        // 5: consumer stalls; a new triple offered meanwhile must be ignored
        launch(1'b0, 3'd1, 4'd9, lat);
        check("t5_latency", 32'(lat), 32'd4);
        @(negedge clk);
        S = 1'b1; E = 3'd0; F = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_stall_dout", 32'(D_out), 32'h012);
            check("t5_stall_valid", 32'(out_valid), 32'd1);
            check("t5_stall_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain(12'h012);
        @(posedge clk); #1;
        check("t5_no_queue", 32'(busy), 32'd0);

        // out_ready already high in NEG: result still shows for one HOLD cycle
        @(negedge clk);
        out_ready = 1'b1;
        S = 1'b0; E = 3'd0; F = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("early_ready_not_valid_yet", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("early_ready_valid", 32'(out_valid), 32'd1);
        check("early_ready_dout", 32'(D_out), 32'h005);
        @(posedge clk); #1;
        check("early_ready_released", 32'(out_valid), 32'd0);
        check("early_ready_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // 6: reset mid-SHIFT aborts immediately, then a clean transaction
        @(negedge clk);
        S = 1'b1; E = 3'd5; F = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_ready", 32'(in_ready), 32'd1);
        check("t6_abort_valid", 32'(out_valid), 32'd0);
        check("t6_abort_dout", 32'(D_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        launch(1'b0, 3'd2, 4'd9, lat);
        check("t6_latency", 32'(lat), 32'd5);
        check("t6_dout", 32'(D_out), 32'h024);
        drain(12'h024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
